// File: rtl/acp_dma_sched_pkg.sv
// acp_dma_sched_pkg: shared state encoding, FIFO size and ring arithmetic for the ACP DMA scheduler.
package acp_dma_sched_pkg;
    localparam int FIFO_DEPTH_DEF = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT    = 3'd1,
        ARB     = 3'd2,
        H2I_RUN = 3'd3,
        I2H_RUN = 3'd4,
        ERR     = 3'd5
    } sched_state_e;

    // (a - b) mod depth; depth is added first so the 17-bit result never goes negative
    function automatic logic [16:0] ring_dist(input logic [15:0] a, input logic [15:0] b, input logic [16:0] depth);
        logic [16:0] t;
        t = {1'b0, a} + depth - {1'b0, b};
        return (t >= depth) ? t - depth : t;
    endfunction

    // free slots = (ci - pi - 1) mod depth
    function automatic logic [16:0] ring_free(input logic [15:0] pi, input logic [15:0] ci, input logic [16:0] depth);
        logic [16:0] d;
        d = ring_dist(ci, pi, depth);
        return ((d == 17'd0) ? depth : d) - 17'd1;
    endfunction
endpackage

// File: rtl/acp_dma_sched_irq.sv
// acp_dma_sched_irq: coalesces ip2hps completions into a level interrupt by count or by age.
module acp_dma_sched_irq (
    input  logic        sys_clk_i,
    input  logic        sys_rst_i,
    input  logic        i2h_done_i,
    input  logic        irq_ack_i,
    input  logic [7:0]  irq_thresh_i,
    input  logic [15:0] irq_timeout_i,
    output logic        irq_o
);
    logic [7:0]  pend_q, pend_d;
    logic [15:0] age_q, age_d;
    logic        irq_q, irq_d;

    always_comb begin
        pend_d = irq_ack_i ? {7'd0, i2h_done_i} : pend_q + {7'd0, i2h_done_i && (pend_q != 8'hFF)};
        age_d  = (irq_ack_i || pend_q == 8'd0) ? 16'd0 : age_q + {15'd0, age_q != 16'hFFFF};
        irq_d  = !irq_ack_i && (irq_q || (pend_d >= ((irq_thresh_i == 8'd0) ? 8'd1 : irq_thresh_i))
                 || (irq_timeout_i != 16'd0 && age_d >= irq_timeout_i));
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            pend_q <= '0;
            age_q  <= '0;
            irq_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            age_q  <= age_d;
            irq_q  <= irq_d;
        end
    end

    assign irq_o = irq_q;
endmodule

// File: rtl/acp_dma_sched.sv
// acp_dma_sched: round-robin burst scheduler for the hps2ip and ip2hps ACP DMA engines,
// with poll interval, per-burst watchdog and completion-interrupt coalescing.
module acp_dma_sched
    import acp_dma_sched_pkg::*;
#(
    parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
    parameter int BURST_LEN   = 4,
    parameter int WDOG_CYCLES = 4096
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_i,
    input  logic        dma_en_i,
    input  logic [31:0] cycle_i,
    input  logic [15:0] hps2ip_pi_i,
    input  logic [15:0] hps2ip_ci_i,
    input  logic [16:0] hps2ip_mindex_i,
    input  logic [15:0] ip2hps_pi_i,
    input  logic [15:0] ip2hps_ci_i,
    input  logic [16:0] ip2hps_mindex_i,
    input  logic [3:0]  fifo_usedw_i,
    input  logic        fifo_empty_i,
    output logic        h2i_go_o,
    input  logic        h2i_done_i,
    output logic        i2h_go_o,
    input  logic        i2h_done_i,
    input  logic [7:0]  irq_thresh_i,
    input  logic [15:0] irq_timeout_i,
    input  logic        irq_ack_i,
    output logic        irq_o,
    output logic        sched_err_o,
    output logic [2:0]  sched_state_o
);
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);

    sched_state_e    state_q;
    logic [31:0]     timer_q;
    logic [WD_W-1:0] wd_q;
    logic            last_h2i_q, h2i_go_q, i2h_go_q, err_q;
    logic            h2i_elig, i2h_elig, run_done;

    assign h2i_elig = (ring_dist(hps2ip_pi_i, hps2ip_ci_i, hps2ip_mindex_i) != 17'd0)
                      && ({28'd0, fifo_usedw_i} <= 32'(FIFO_DEPTH - BURST_LEN));
    assign i2h_elig = !fifo_empty_i && (ring_free(ip2hps_pi_i, ip2hps_ci_i, ip2hps_mindex_i) != 17'd0);
    assign run_done = (state_q == H2I_RUN) ? h2i_done_i : i2h_done_i;

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            wd_q       <= '0;
            last_h2i_q <= 1'b0;
            h2i_go_q   <= 1'b0;
            i2h_go_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            h2i_go_q <= 1'b0;
            i2h_go_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    timer_q <= '0;
                    if (dma_en_i) state_q <= WAIT;
                end
                WAIT: begin
                    if (!dma_en_i) state_q <= IDLE;
                    else if (timer_q >= cycle_i) state_q <= ARB;
                    else timer_q <= timer_q + 32'd1;
                end
                ARB: begin
                    timer_q <= '0;
                    wd_q    <= '0;
                    // on a tie the engine not served last wins
                    if (!dma_en_i) state_q <= IDLE;
                    else if (h2i_elig && (!i2h_elig || !last_h2i_q)) begin
                        h2i_go_q <= 1'b1;
                        state_q  <= H2I_RUN;
                    end else if (i2h_elig) begin
                        i2h_go_q <= 1'b1;
                        state_q  <= I2H_RUN;
                    end else state_q <= WAIT;
                end
                H2I_RUN, I2H_RUN: begin
                    if (run_done) begin
                        last_h2i_q <= (state_q == H2I_RUN);
                        timer_q    <= '0;
                        state_q    <= dma_en_i ? WAIT : IDLE;
                    end else if (wd_q == WD_W'(WDOG_CYCLES - 1)) begin
                        err_q   <= 1'b1;
                        state_q <= ERR;
                    end else wd_q <= wd_q + WD_W'(1);
                end
                ERR: if (!dma_en_i) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    acp_dma_sched_irq u_irq (
        .sys_clk_i     (sys_clk_i),
        .sys_rst_i     (sys_rst_i),
        .i2h_done_i    (i2h_done_i),
        .irq_ack_i     (irq_ack_i),
        .irq_thresh_i  (irq_thresh_i),
        .irq_timeout_i (irq_timeout_i),
        .irq_o         (irq_o)
    );

    assign h2i_go_o      = h2i_go_q;
    assign i2h_go_o      = i2h_go_q;
    assign sched_err_o   = err_q;
    assign sched_state_o = state_q;
endmodule

// File: doc/acp_dma_sched.md
Name: acp_dma_sched

Overview:
- Scheduler that sequences the two ACP DMA engines: hps2ip (ring to FIFO) and ip2hps (FIFO to ring).
- Watches ring pointers and shared FIFO level, and grants one engine burst at a time, round-robin.
- Adds a poll interval, a per-burst watchdog and completion-interrupt coalescing.
- Sits between the CSR block and the DMA engines in the ACP top level.

Parameters:
- FIFO_DEPTH, 16, shared FIFO entries (256-bit each).
- BURST_LEN, 4, FIFO entries moved per engine grant.
- WDOG_CYCLES, 4096, max clocks from grant pulse to done before error.

Ports:
- sys_clk  in  1  clock.
- sys_rst  in  1  synchronous active-high reset.
- dma_en  in  1  global enable from CSR.
- cycle  in  32  poll interval in clocks; 0 = poll every cycle.
- hps2ip_pi  in  16  host producer index, hps2ip ring.
- hps2ip_ci  in  16  engine consumer index, hps2ip ring.
- hps2ip_mindex  in  17  hps2ip ring depth in entries, 1..65536.
- ip2hps_pi  in  16  engine producer index, ip2hps ring.
- ip2hps_ci  in  16  host consumer index, ip2hps ring.
- ip2hps_mindex  in  17  ip2hps ring depth in entries.
- fifo_usedw  in  4  shared FIFO fill level.
- fifo_empty  in  1  shared FIFO empty.
- h2i_go  out  1  one-cycle grant pulse to hps2ip engine.
- h2i_done  in  1  hps2ip burst complete pulse.
- i2h_go  out  1  one-cycle grant pulse to ip2hps engine.
- i2h_done  in  1  ip2hps burst complete pulse.
- irq_thresh  in  8  coalesce count; 0 = irq on every i2h_done.
- irq_timeout  in  16  coalesce timeout in clocks; 0 = disabled.
- irq_ack  in  1  host acknowledge pulse.
- irq  out  1  level interrupt.
- sched_err  out  1  sticky watchdog error.
- sched_state  out  3  current FSM state, for CSR readback.

Behaviour:
- Reset values: h2i_go=0, i2h_go=0, irq=0, sched_err=0, sched_state=IDLE. All counters 0; round-robin pointer favours hps2ip first.
- FSM states (encoding): IDLE(0), WAIT(1), ARB(2), H2I_RUN(3), I2H_RUN(4), ERR(5).
- IDLE: go to WAIT when dma_en=1; poll timer loads 0.
- WAIT: timer increments each clock. Go to ARB when timer >= cycle.
- ARB, single cycle:
  - h2i_elig = (hps2ip_pi != hps2ip_ci) && (fifo_usedw <= FIFO_DEPTH-BURST_LEN).
  - i2h_elig = !fifo_empty && ip2hps_free != 0, where ip2hps_free = (ip2hps_ci - ip2hps_pi - 1) mod ip2hps_mindex, computed in 17 bits. Add mindex before subtracting so the result is never negative.
  - Both eligible: grant the engine not granted last. One eligible: grant it. None: back to WAIT with timer cleared.
  - The grant asserts the matching go for exactly one cycle (registered, 1-cycle latency from ARB) and enters *_RUN.
- *_RUN: wait for the matching done, then update the rr pointer and go to WAIT (timer cleared).
  - Watchdog counts from the go pulse. Reaching WDOG_CYCLES without done sets sched_err and enters ERR.
  - A done arriving in the same cycle as expiry wins: no error.
- ERR: no grants are issued. Leave only by sys_rst, or by dma_en falling, which goes to IDLE. sched_err stays set until sys_rst.
- dma_en falling in WAIT/ARB: go to IDLE next cycle.
- dma_en falling in *_RUN: finish the burst, wait for done, then go to IDLE. A go is never cancelled.
- Done pulses for the non-granted engine are ignored by the FSM. i2h_done still counts toward irq in any state.
- Coalescing:
  - i2h_done increments the 8-bit pend_cnt, saturating at 255.
  - Age timer runs while pend_cnt != 0.
  - irq sets (registered) when pend_cnt >= max(irq_thresh,1), or when irq_timeout != 0 and age >= irq_timeout.
  - irq_ack clears irq, pend_cnt and age. If irq_ack and i2h_done occur in the same cycle, pend_cnt = 1 and age = 0.
- sys_rst mid-burst: FSM returns to IDLE and all outputs take their reset values. The engines are reset by the same signal.

Decomposition:
- Shared package acp_pkg holds:
  - FSM state localparams (IDLE..ERR, 3-bit).
  - The 17-bit ring-distance function (pi, ci, depth).
  - FIFO_DEPTH.
- One natural sub-module: acp_irq_coalesce, containing pend_cnt, the age timer, irq and the ack logic.

Test Plan:
- Basic hps2ip grant: reset, dma_en=1, cycle=0, hps2ip_pi=5, ci=0, usedw=0. Expect one h2i_go pulse 2 clocks after enable. Pulse h2i_done; expect state WAIT, then another h2i_go.
- Round-robin: both engines eligible (usedw=4, fifo_empty=0, ip2hps pi=0, ci=0, depth=8). Expect go order h2i, i2h, h2i, i2h across four bursts. With usedw=13, expect only i2h_go.
- Ring full and wrap: ip2hps_pi=7, ci=0, depth=8 gives free=0, so no i2h_go. Set ci=1: free=1, i2h_go issued. Check pi=0, ci=7: free=6.
- Watchdog: grant h2i and withhold done for 4096 clocks. Expect sched_err=1 and state ERR, no further go. Drop dma_en: state IDLE, sched_err still 1.
- Coalescing: irq_thresh=3, timeout=0, three i2h_done pulses give irq on the 3rd+1 cycle. irq_ack with a simultaneous done leaves irq low and pend_cnt=1. Then thresh=10, timeout=100, one done gives irq 100 clocks later.
- Poll interval: cycle=50. Expect at least 50 clocks between done and the next go. Reset during H2I_RUN: all outputs at reset values the next cycle.
